host_bus_master: RTL and testbench



---
 rtl/host_bus_master_pkg.sv | 38 +++
 rtl/host_bus_master_phase.sv | 54 +++++
 rtl/host_bus_master.sv | 184 ++++++++++++++++++
 tb/tb_host_bus_master.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_bus_master_pkg.sv
// Shared widths, default strobe timing and state encodings for the host bus master.
// The master FSM and the phase sequencer both import this package.
package host_bus_master_pkg;
    localparam int HOST_BUS_AW    = 11;
    localparam int HOST_BANK_W    = 2;
    localparam int VRAM_AW        = HOST_BUS_AW + HOST_BANK_W;
    localparam int HOST_DATA_W    = 8;
    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 2;
    localparam int DEF_HOLD_CYC   = 1;
    localparam int PH_CNT_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B_SETUP,
        ST_B_STROBE,
        ST_B_HOLD,
        ST_A_SETUP,
        ST_A_STROBE,
        ST_A_HOLD,
        ST_DONE
    } hbm_state_t;

    typedef enum logic [1:0] {
        PH_OFF,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_t;

    function automatic logic is_bank_state(hbm_state_t s);
        return (s == ST_B_SETUP) || (s == ST_B_STROBE) || (s == ST_B_HOLD);
    endfunction

    function automatic logic is_access_state(hbm_state_t s);
        return (s == ST_A_SETUP) || (s == ST_A_STROBE) || (s == ST_A_HOLD);
    endfunction
endpackage

// File: rtl/host_bus_master_phase.sv
// Setup/strobe/hold sequencer: one down-counter reloaded on every step entry.
// i_start begins a new setup step at the next edge; o_done marks the final hold cycle.
module host_bus_phase
    import host_bus_master_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_strobe,
    output logic o_last,
    output logic o_done
);
    localparam logic [PH_CNT_W-1:0] SETUP_LD  = PH_CNT_W'(SETUP_CYC - 1);
    localparam logic [PH_CNT_W-1:0] STROBE_LD = PH_CNT_W'(STROBE_CYC - 1);
    localparam logic [PH_CNT_W-1:0] HOLD_LD   = PH_CNT_W'(HOLD_CYC - 1);

    phase_t              r_step;
    logic [PH_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step <= PH_OFF;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_step <= PH_SETUP;
            r_cnt  <= SETUP_LD;
        end else if (r_step != PH_OFF && r_cnt == '0) begin
            case (r_step)
                PH_SETUP: begin
                    r_step <= PH_STROBE;
                    r_cnt  <= STROBE_LD;
                end
                PH_STROBE: begin
                    r_step <= PH_HOLD;
                    r_cnt  <= HOLD_LD;
                end
                default: begin
                    r_step <= PH_OFF;
                    r_cnt  <= '0;
                end
            endcase
        end else if (r_step != PH_OFF) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_last   = (r_step != PH_OFF) && (r_cnt == '0);
    assign o_strobe = (r_step == PH_STROBE);
    assign o_done   = (r_step == PH_HOLD) && (r_cnt == '0);
endmodule

// File: rtl/host_bus_master.sv
// Host bus initiator: turns valid/ready VRAM requests into timed host-bus cycles,
// inserting a bank register write whenever the cached bank does not match.
module host_bus_master
    import host_bus_master_pkg::*;
#(
    parameter int BUS_AW     = HOST_BUS_AW,
    parameter int BANK_W     = HOST_BANK_W,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [BUS_AW+BANK_W-1:0] req_addr,
    input  logic [7:0]               req_wdata,
    output logic                     rsp_valid,
    output logic [7:0]               rsp_rdata,
    output logic [BUS_AW-1:0]        hostBusAddr,
    inout  wire  [7:0]               hostBusData,
    output logic                     nHostRMEM,
    output logic                     nHostWMEM,
    output logic                     nHostVRAMEn,
    output logic                     nHostBankRegEn
);
    localparam int AW = BUS_AW + BANK_W;

    hbm_state_t          r_state;
    hbm_state_t          w_next;
    logic                r_bank_valid;
    logic [BANK_W-1:0]   r_cur_bank;
    logic                r_write;
    logic [AW-1:0]       r_addr;
    logic [7:0]          r_wdata;
    logic                r_ready;
    logic                r_rsp_valid;
    logic [7:0]          r_rdata;
    logic [BUS_AW-1:0]   r_bus_addr;
    logic [7:0]          r_dout;
    logic                r_oe;
    logic                r_nrmem;
    logic                r_nwmem;
    logic                r_nven;
    logic                r_nben;

    logic                w_accept;
    logic                w_need_bank;
    logic                w_start;
    logic                w_strobe;
    logic                w_last;
    logic                w_done;
    logic                w_write;
    logic [AW-1:0]       w_addr;
    logic [7:0]          w_wdata;
    logic [7:0]          w_bank_byte;

    host_bus_phase #(
        .SETUP_CYC (SETUP_CYC),
        .STROBE_CYC(STROBE_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_phase (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .o_strobe(w_strobe),
        .o_last  (w_last),
        .o_done  (w_done)
    );

    assign w_accept    = req_valid && r_ready;
    assign w_need_bank = !r_bank_valid || (req_addr[AW-1:BUS_AW] != r_cur_bank);

    // On the accepting edge the bus outputs must come from the live request, not the capture regs.
    assign w_addr  = w_accept ? req_addr  : r_addr;
    assign w_write = w_accept ? req_write : r_write;
    assign w_wdata = w_accept ? req_wdata : r_wdata;

    always_comb begin
        w_bank_byte                = '0;
        w_bank_byte[BANK_W-1:0]    = w_addr[AW-1:BUS_AW];
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_start = 1'b1;
                    w_next  = w_need_bank ? ST_B_SETUP : ST_A_SETUP;
                end
            end
            ST_B_SETUP:  if (w_last) w_next = ST_B_STROBE;
            ST_B_STROBE: if (w_last) w_next = ST_B_HOLD;
            ST_B_HOLD: begin
                if (w_done) begin
                    w_start = 1'b1;
                    w_next  = ST_A_SETUP;
                end
            end
            ST_A_SETUP:  if (w_last) w_next = ST_A_STROBE;
            ST_A_STROBE: if (w_last) w_next = ST_A_HOLD;
            ST_A_HOLD:   if (w_done) w_next = ST_DONE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Bus pins are decoded from the next state so every pin is a flop and changes on the state edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_bank_valid <= 1'b0;
            r_cur_bank   <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ready      <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rdata      <= '0;
            r_bus_addr   <= '0;
            r_dout       <= '0;
            r_oe         <= 1'b0;
            r_nrmem      <= 1'b1;
            r_nwmem      <= 1'b1;
            r_nven       <= 1'b1;
            r_nben       <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_ready     <= (w_next == ST_IDLE);
            r_rsp_valid <= (w_next == ST_DONE);

            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end

            if (r_state == ST_B_HOLD && w_done) begin
                r_cur_bank   <= r_addr[AW-1:BUS_AW];
                r_bank_valid <= 1'b1;
            end

            if (r_state == ST_A_STROBE && w_strobe && w_last && !r_write) begin
                r_rdata <= hostBusData;
            end

            r_nrmem    <= 1'b1;
            r_nwmem    <= 1'b1;
            r_nven     <= 1'b1;
            r_nben     <= 1'b1;
            r_oe       <= 1'b0;
            r_bus_addr <= '0;
            r_dout     <= '0;
            if (is_bank_state(w_next)) begin
                r_nben  <= 1'b0;
                r_oe    <= 1'b1;
                r_dout  <= w_bank_byte;
                r_nwmem <= (w_next != ST_B_STROBE);
            end else if (is_access_state(w_next)) begin
                r_nven     <= 1'b0;
                r_bus_addr <= w_addr[BUS_AW-1:0];
                if (w_write) begin
                    r_oe    <= 1'b1;
                    r_dout  <= w_wdata;
                    r_nwmem <= (w_next != ST_A_STROBE);
                end else begin
                    r_nrmem <= (w_next != ST_A_STROBE);
                end
            end
        end
    end

    assign req_ready      = r_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rdata;
    assign hostBusAddr    = r_bus_addr;
    assign hostBusData    = r_oe ? r_dout : 8'hzz;
    assign nHostRMEM      = r_nrmem;
    assign nHostWMEM      = r_nwmem;
    assign nHostVRAMEn    = r_nven;
    assign nHostBankRegEn = r_nben;
endmodule

// File: tb/tb_host_bus_master.sv
// Bench for host_bus_master: behavioural bus target, protocol monitor and a
// transaction-level reference model of bank caching, latency and read data.
module tb_host_bus_master;
  localparam int S     = 1;
  localparam int W     = 2;
  localparam int H     = 1;
  localparam int LAT_A = 1 + S + W + H;
  localparam int LAT_B = 5 + S + W + H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [12:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  wire         req_ready;
  wire         rsp_valid;
  wire  [7:0]  rsp_rdata;
  wire  [10:0] hostBusAddr;
  wire  [7:0]  hostBusData;
  wire         nHostRMEM;
  wire         nHostWMEM;
  wire         nHostVRAMEn;
  wire         nHostBankRegEn;
  logic        tb_probe = 1'b0;

  logic [7:0]  tgt_mem [0:8191];
  logic [1:0]  tgt_bank = 2'd0;
  logic [7:0]  m_mem [0:8191];
  logic [1:0]  m_bank = 2'd0;
  bit          m_bank_valid = 1'b0;
  logic [7:0]  m_last_rd = 8'h00;

  logic [1:0]  exp_bank_q[$];
  logic [1:0]  got_bank_q[$];
  logic [20:0] exp_q[$];
  logic [20:0] got_wr_q[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  host_bus_master dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .hostBusAddr   (hostBusAddr),
    .hostBusData   (hostBusData),
    .nHostRMEM     (nHostRMEM),
    .nHostWMEM     (nHostWMEM),
    .nHostVRAMEn   (nHostVRAMEn),
    .nHostBankRegEn(nHostBankRegEn)
  );

  // Target answers reads; the probe drives zero so any master drive shows up as nonzero.
  assign hostBusData = (!nHostRMEM && !nHostVRAMEn) ? tgt_mem[{tgt_bank, hostBusAddr}] : 8'hzz;
  assign hostBusData = tb_probe ? 8'h00 : 8'hzz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge nHostWMEM) begin
    if (!rst) begin
      if (!nHostBankRegEn) begin
        tgt_bank = hostBusData[1:0];
        got_bank_q.push_back(hostBusData[1:0]);
      end
      if (!nHostVRAMEn) begin
        tgt_mem[{tgt_bank, hostBusAddr}] = hostBusData;
        got_wr_q.push_back({tgt_bank, hostBusAddr, hostBusData});
      end
    end
  end

  logic        p_w = 1'b1, p_r = 1'b1, p_v = 1'b1, p_b = 1'b1, p_rst = 1'b1;
  logic [10:0] p_a = '0;
  logic [7:0]  p_d = '0;
  int          w_lo = 0, r_lo = 0;

  always @(negedge clk) begin
    if (!rst && !p_rst) begin
      if (!nHostVRAMEn || !nHostBankRegEn)
        check_eq("en_overlap", 32'(!nHostVRAMEn && !nHostBankRegEn), 32'd0);
      if (!nHostRMEM)
        check_eq("rd_bus_drive", 32'(hostBusData), 32'(tgt_mem[{tgt_bank, hostBusAddr}]));
      if (p_w && !nHostWMEM)
        check_eq("wr_setup", 32'(p_a == hostBusAddr && p_d == hostBusData && p_v == nHostVRAMEn
                                 && p_b == nHostBankRegEn && !(p_v && p_b)), 32'd1);
      if (!p_w && nHostWMEM) begin
        check_eq("wr_hold", 32'(p_a == hostBusAddr && p_d == hostBusData && p_v == nHostVRAMEn
                                && p_b == nHostBankRegEn && !(p_v && p_b)), 32'd1);
        check_eq("wr_low_len", 32'(w_lo), 32'(W));
      end
      if (p_r && !nHostRMEM)
        check_eq("rd_setup", 32'(p_a == hostBusAddr && !p_v && !nHostVRAMEn), 32'd1);
      if (!p_r && nHostRMEM) begin
        check_eq("rd_hold", 32'(p_a == hostBusAddr && !p_v && !nHostVRAMEn), 32'd1);
        check_eq("rd_low_len", 32'(r_lo), 32'(W));
      end
    end
    w_lo  = (!rst && !nHostWMEM) ? w_lo + 1 : 0;
    r_lo  = (!rst && !nHostRMEM) ? r_lo + 1 : 0;
    p_w   = nHostWMEM;
    p_r   = nHostRMEM;
    p_v   = nHostVRAMEn;
    p_b   = nHostBankRegEn;
    p_a   = hostBusAddr;
    p_d   = hostBusData;
    p_rst = rst;
  end

  task automatic compare_queues(input string tag);
    check_eq({tag, "_bank_cnt"}, 32'(got_bank_q.size()), 32'(exp_bank_q.size()));
    while (got_bank_q.size() > 0 && exp_bank_q.size() > 0)
      check_eq({tag, "_bank_val"}, 32'(got_bank_q.pop_front()), 32'(exp_bank_q.pop_front()));
    check_eq({tag, "_wr_cnt"}, 32'(got_wr_q.size()), 32'(exp_q.size()));
    while (got_wr_q.size() > 0 && exp_q.size() > 0)
      check_eq({tag, "_wr_val"}, 32'(got_wr_q.pop_front()), 32'(exp_q.pop_front()));
    got_bank_q.delete();
    exp_bank_q.delete();
    got_wr_q.delete();
    exp_q.delete();
  endtask

  // Model update at acceptance: a bank write is expected whenever the cached bank is absent or differs.
  task automatic model_accept(input bit wr, input logic [12:0] a, input logic [7:0] d, output bit need_bank);
    need_bank = !m_bank_valid || (a[12:11] != m_bank);
    if (need_bank) begin
      exp_bank_q.push_back(a[12:11]);
      m_bank       = a[12:11];
      m_bank_valid = 1'b1;
    end
    if (wr) begin
      exp_q.push_back({a, d});
      m_mem[a] = d;
    end
  endtask

  task automatic wait_ready(output bit ok);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    ok = req_ready;
    if (!ok) check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input bit wr, input logic [12:0] a, input logic [7:0] d);
    bit ok;
    bit need_bank;
    int lat = 0;
    wait_ready(ok);
    if (ok) begin
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = 13'($urandom);
      req_wdata = 8'($urandom);
      model_accept(wr, a, d, need_bank);
      if (!wr) m_last_rd = m_mem[a];
      do begin
        @(negedge clk);
        lat++;
      end while (!rsp_valid && lat < 30);
      check_eq(wr ? "wr_latency" : "rd_latency", 32'(lat), 32'(need_bank ? LAT_B : LAT_A));
      check_eq("rsp_rdata", 32'(rsp_rdata), 32'(m_last_rd));
      @(negedge clk);
      check_eq("rsp_pulse", 32'(rsp_valid), 32'd0);
      compare_queues("txn");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  v;
    logic [12:0] a;
    logic [1:0]  ab;
    logic [7:0]  b2b_d [4];
    bit          ok;
    bit          nb;
    int          guard;
    int          seen;
    int          cyc, idx, last_acc, ready_cnt, rsp_cnt;

    for (int i = 0; i < 8192; i++) begin
      v = 8'($urandom);
      tgt_mem[i] = v;
      m_mem[i]   = v;
    end

    tb_probe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_pins", 32'({nHostRMEM, nHostWMEM, nHostVRAMEn, nHostBankRegEn}), 32'hf);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("rst_addr", 32'(hostBusAddr), 32'd0);
    check_eq("rst_data_z", 32'(hostBusData), 32'd0);
    tb_probe = 1'b0;
    rst = 1'b0;

    do_req(1'b1, 13'h0123, 8'h41);
    do_req(1'b1, 13'h0124, 8'h42);
    check_eq("tgt_0124", 32'(tgt_mem[13'h0124]), 32'h42);
    do_req(1'b0, 13'h0123, 8'h00);
    do_req(1'b1, 13'h1FFF, 8'h7E);
    do_req(1'b0, 13'h07FF, 8'h00);
    do_req(1'b1, 13'h07FF, 8'h11);
    do_req(1'b1, 13'h0800, 8'h22);
    do_req(1'b0, 13'h1FFF, 8'h00);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       a = {2'($urandom_range(0, 3)), 11'h000};
        1:       a = {2'($urandom_range(0, 3)), 11'h7FF};
        2:       a = {2'($urandom_range(0, 3)), 11'h400 + 11'($urandom_range(0, 3))};
        default: a = 13'($urandom);
      endcase
      do_req(1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    // Abort a write mid-strobe in a freshly selected bank.
    ab = m_bank + 2'd1;
    a  = {ab, 11'h055};
    wait_ready(ok);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_wdata = 8'h5C;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    model_accept(1'b0, a, 8'h00, nb);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(!nHostWMEM && !nHostVRAMEn) && guard < 30);
    check_eq("abort_reach_strobe", 32'(!nHostWMEM && !nHostVRAMEn), 32'd1);
    #1;
    rst      = 1'b1;
    tb_probe = 1'b1;
    #1;
    check_eq("abort_pins", 32'({nHostRMEM, nHostWMEM, nHostVRAMEn, nHostBankRegEn}), 32'hf);
    check_eq("abort_data_z", 32'(hostBusData), 32'd0);
    check_eq("abort_rsp", 32'(rsp_valid), 32'd0);
    tb_probe     = 1'b0;
    m_bank_valid = 1'b0;
    m_last_rd    = 8'h00;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check_eq("abort_no_rsp", 32'(seen), 32'd0);
    compare_queues("abort");
    do_req(1'b1, {ab, 11'h056}, 8'h9A);

    // Back-to-back writes in one bank with req_valid held high.
    do_req(1'b1, {2'd2, 11'h010}, 8'h01);
    for (int i = 0; i < 4; i++) b2b_d[i] = 8'($urandom);
    idx = 0; cyc = 0; last_acc = -1; ready_cnt = 0; rsp_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = {2'd2, 11'h020};
    req_wdata = b2b_d[0];
    while (cyc < 60 && !(idx == 4 && rsp_cnt == 4)) begin
      if (req_ready && idx < 4) begin
        ready_cnt++;
        if (last_acc >= 0) check_eq("b2b_period", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
        model_accept(1'b1, req_addr, req_wdata, nb);
        idx++;
        @(posedge clk);
        #1;
        if (idx < 4) begin
          req_addr  = {2'd2, 11'h020 + 11'(idx)};
          req_wdata = b2b_d[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
      if (rsp_valid) rsp_cnt++;
    end
    req_valid = 1'b0;
    check_eq("b2b_accepts", 32'(ready_cnt), 32'd4);
    check_eq("b2b_rsps", 32'(rsp_cnt), 32'd4);
    compare_queues("b2b");
    do_req(1'b0, {2'd2, 11'h022}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
